// File: rtl/out_of_order_buffer_arbiter.sv
// Round-robin write/read arbiter in front of a shared out-of-order buffer, with per-requester quota.
// Define OUT_OF_ORDER_BUFFER_ARBITER_OWNERSHIP_CHECK_EN to keep a slot owner table that blocks foreign clears.
module out_of_order_buffer_arbiter #(
    parameter int WIDTH           = 8,
    parameter int DEPTH           = 8,
    parameter int INDEX_WIDTH     = $clog2(DEPTH),
    parameter int REQUESTERS      = 4,
    parameter int REQUESTER_WIDTH = $clog2(REQUESTERS),
    parameter int QUOTA           = DEPTH / 2
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [REQUESTERS-1:0]                     write_request,
    input  logic [REQUESTERS*WIDTH-1:0]               write_data,
    output logic [REQUESTERS-1:0]                     write_grant,
    output logic [INDEX_WIDTH-1:0]                    write_index,
    input  logic [REQUESTERS-1:0]                     read_request,
    input  logic [REQUESTERS-1:0]                     read_clear,
    input  logic [REQUESTERS*INDEX_WIDTH-1:0]         read_index,
    output logic [REQUESTERS-1:0]                     read_grant,
    output logic [WIDTH-1:0]                          read_data,
    output logic                                      read_error,
    output logic [REQUESTERS*($clog2(QUOTA+1))-1:0]   outstanding,
    output logic                                      buffer_resetn,
    output logic                                      buffer_write_enable,
    output logic [WIDTH-1:0]                          buffer_write_data,
    input  logic [INDEX_WIDTH-1:0]                    buffer_write_index,
    input  logic                                      buffer_full,
    output logic                                      buffer_read_enable,
    output logic                                      buffer_read_clear,
    output logic [INDEX_WIDTH-1:0]                    buffer_read_index,
    input  logic [WIDTH-1:0]                          buffer_read_data,
    input  logic                                      buffer_read_error
);

    localparam int COUNT_WIDTH = $clog2(QUOTA + 1);

    logic [REQUESTER_WIDTH-1:0] write_pointer;
    logic [REQUESTER_WIDTH-1:0] read_pointer;
    logic [COUNT_WIDTH-1:0]     count [REQUESTERS];

    logic                       write_found;
    logic [REQUESTER_WIDTH-1:0] write_winner;
    logic                       read_found;
    logic [REQUESTER_WIDTH-1:0] read_winner;
    logic [INDEX_WIDTH-1:0]     read_slot;
    logic                       owner_mismatch;
    logic                       count_decrement;
    logic [REQUESTERS-1:0]      decrement_vector;

    // Write side: first eligible client at or after the pointer, wrapping.
    always_comb begin
        int candidate;
        candidate    = 0;
        write_found  = 1'b0;
        write_winner = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            candidate = int'(write_pointer) + k;
            if (candidate >= REQUESTERS) candidate = candidate - REQUESTERS;
            if (!write_found && write_request[candidate] &&
                count[candidate] < COUNT_WIDTH'(QUOTA)) begin
                write_found  = 1'b1;
                write_winner = REQUESTER_WIDTH'(candidate);
            end
        end
    end

    always_comb begin
        int candidate;
        candidate   = 0;
        read_found  = 1'b0;
        read_winner = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            candidate = int'(read_pointer) + k;
            if (candidate >= REQUESTERS) candidate = candidate - REQUESTERS;
            if (!read_found && read_request[candidate]) begin
                read_found  = 1'b1;
                read_winner = REQUESTER_WIDTH'(candidate);
            end
        end
    end

    always_comb begin
        write_grant       = '0;
        buffer_write_data = '0;
        if (!reset && !buffer_full && write_found) begin
            write_grant[write_winner] = 1'b1;
            buffer_write_data         = write_data[write_winner*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        read_grant        = '0;
        buffer_read_index = '0;
        if (!reset && read_found) begin
            read_grant[read_winner] = 1'b1;
            buffer_read_index       = read_slot;
        end
    end

    assign read_slot           = read_index[read_winner*INDEX_WIDTH +: INDEX_WIDTH];
    assign buffer_write_enable = |write_grant;
    assign buffer_read_enable  = |read_grant;
    assign write_index         = buffer_write_index;
    assign read_data           = buffer_read_data;
    assign buffer_resetn       = ~reset;

`ifdef OUT_OF_ORDER_BUFFER_ARBITER_OWNERSHIP_CHECK_EN
    logic [REQUESTER_WIDTH-1:0] owner [DEPTH];

    assign owner_mismatch = buffer_read_enable && (owner[read_slot] != read_winner);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < DEPTH; s++) owner[s] <= '0;
        end else if (buffer_write_enable) begin
            owner[write_index] <= write_winner;
        end
    end
`else
    assign owner_mismatch = 1'b0;
`endif

    // A clear on an invalid slot still goes to the buffer, but only a clean clear frees quota.
    assign read_error        = buffer_read_enable & (buffer_read_error | owner_mismatch);
    assign buffer_read_clear = buffer_read_enable & read_clear[read_winner] & ~owner_mismatch;
    assign count_decrement   = buffer_read_clear & ~buffer_read_error;
    assign decrement_vector  = count_decrement ? read_grant : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            write_pointer <= '0;
            read_pointer  <= '0;
            for (int i = 0; i < REQUESTERS; i++) count[i] <= '0;
        end else begin
            if (buffer_write_enable) begin
                write_pointer <= (write_winner == REQUESTER_WIDTH'(REQUESTERS - 1)) ?
                                 '0 : write_winner + 1'b1;
            end
            if (buffer_read_enable) begin
                read_pointer <= (read_winner == REQUESTER_WIDTH'(REQUESTERS - 1)) ?
                                '0 : read_winner + 1'b1;
            end
            for (int i = 0; i < REQUESTERS; i++) begin
                if (write_grant[i] && !decrement_vector[i] &&
                    count[i] < COUNT_WIDTH'(QUOTA)) begin
                    count[i] <= count[i] + 1'b1;
                end else if (decrement_vector[i] && !write_grant[i] &&
                             count[i] != '0) begin
                    count[i] <= count[i] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        outstanding = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            outstanding[i*COUNT_WIDTH +: COUNT_WIDTH] = count[i];
        end
    end

endmodule

// File: tb/tb_out_of_order_buffer_arbiter.sv
// Bench for out_of_order_buffer_arbiter: behavioural buffer, vector table, corner sequences, random traffic.
module tb_out_of_order_buffer_arbiter;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int IW    = 3;
    localparam int R     = 4;
    localparam int QUOTA = 4;
    localparam int CW    = 3;
`ifdef OUT_OF_ORDER_BUFFER_ARBITER_OWNERSHIP_CHECK_EN
    localparam bit OWN = 1'b1;
`else
    localparam bit OWN = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                 reset;
    logic [R-1:0]         write_request;
    logic [R*WIDTH-1:0]   write_data;
    logic [R-1:0]         write_grant;
    logic [IW-1:0]        write_index;
    logic [R-1:0]         read_request;
    logic [R-1:0]         read_clear;
    logic [R*IW-1:0]      read_index;
    logic [R-1:0]         read_grant;
    logic [WIDTH-1:0]     read_data;
    logic                 read_error;
    logic [R*CW-1:0]      outstanding;
    logic                 buffer_resetn;
    logic                 buffer_write_enable;
    logic [WIDTH-1:0]     buffer_write_data;
    logic [IW-1:0]        buffer_write_index;
    logic                 buffer_full;
    logic                 buffer_read_enable;
    logic                 buffer_read_clear;
    logic [IW-1:0]        buffer_read_index;
    logic [WIDTH-1:0]     buffer_read_data;
    logic                 buffer_read_error;

    out_of_order_buffer_arbiter dut (
        .clock(clock), .reset(reset),
        .write_request(write_request), .write_data(write_data),
        .write_grant(write_grant), .write_index(write_index),
        .read_request(read_request), .read_clear(read_clear), .read_index(read_index),
        .read_grant(read_grant), .read_data(read_data), .read_error(read_error),
        .outstanding(outstanding), .buffer_resetn(buffer_resetn),
        .buffer_write_enable(buffer_write_enable), .buffer_write_data(buffer_write_data),
        .buffer_write_index(buffer_write_index), .buffer_full(buffer_full),
        .buffer_read_enable(buffer_read_enable), .buffer_read_clear(buffer_read_clear),
        .buffer_read_index(buffer_read_index), .buffer_read_data(buffer_read_data),
        .buffer_read_error(buffer_read_error)
    );

    // Out-of-order buffer: lowest free slot allocated, slot freed on the edge after a clear.
    logic [DEPTH-1:0] bvalid;
    logic [WIDTH-1:0] bdata [DEPTH];

    always_comb begin
        buffer_full        = &bvalid;
        buffer_write_index = '0;
        for (int i = DEPTH - 1; i >= 0; i--) if (!bvalid[i]) buffer_write_index = IW'(i);
        buffer_read_data  = bdata[buffer_read_index];
        buffer_read_error = !bvalid[buffer_read_index];
    end

    always @(posedge clock) begin
        if (!buffer_resetn) begin
            bvalid <= '0;
            for (int s = 0; s < DEPTH; s++) bdata[s] <= '0;
        end else begin
            if (buffer_write_enable) begin
                bvalid[buffer_write_index] <= 1'b1;
                bdata[buffer_write_index]  <= buffer_write_data;
            end
            if (buffer_read_enable && buffer_read_clear && bvalid[buffer_read_index])
                bvalid[buffer_read_index] <= 1'b0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: slot table, owners, counts and pointers as plain integers.
    int              m_wptr, m_rptr;
    int              m_cnt   [R];
    int              m_owner [DEPTH];
    bit              m_valid [DEPTH];
    logic [WIDTH-1:0] m_data [DEPTH];
    int              e_wwin, e_rwin, e_free, e_ridx;
    bit              e_berr, e_mism, e_clr;

    task automatic model_check();
        bit full;
        int c;
        if (reset) begin
            e_wwin = -1;
            e_rwin = -1;
            chk("reset write_grant", write_grant, 0);
            chk("reset read_grant", read_grant, 0);
            chk("reset buffer_write_enable", buffer_write_enable, 0);
            chk("reset buffer_read_enable", buffer_read_enable, 0);
            chk("reset read_error", read_error, 0);
            chk("reset buffer_resetn", buffer_resetn, 0);
        end else begin
            full   = 1'b1;
            e_free = 0;
            for (int s = DEPTH - 1; s >= 0; s--) if (!m_valid[s]) begin full = 1'b0; e_free = s; end
            e_wwin = -1;
            if (!full)
                for (int k = 0; k < R; k++) begin
                    c = (m_wptr + k) % R;
                    if (e_wwin < 0 && write_request[c] && m_cnt[c] < QUOTA) e_wwin = c;
                end
            e_rwin = -1;
            for (int k = 0; k < R; k++) begin
                c = (m_rptr + k) % R;
                if (e_rwin < 0 && read_request[c]) e_rwin = c;
            end
            chk("write_grant", write_grant, (e_wwin >= 0) ? (32'd1 << e_wwin) : 32'd0);
            chk("buffer_write_enable", buffer_write_enable, (e_wwin >= 0) ? 1 : 0);
            if (e_wwin >= 0) begin
                chk("write_index", write_index, e_free);
                chk("buffer_write_data", buffer_write_data, write_data[e_wwin*WIDTH +: WIDTH]);
            end
            if (e_rwin >= 0) begin
                e_ridx = int'(read_index[e_rwin*IW +: IW]);
                e_berr = !m_valid[e_ridx];
                e_mism = OWN && (m_owner[e_ridx] != e_rwin);
                e_clr  = read_clear[e_rwin] && !e_mism;
                chk("read_grant", read_grant, 32'd1 << e_rwin);
                chk("buffer_read_enable", buffer_read_enable, 1);
                chk("buffer_read_index", buffer_read_index, e_ridx);
                chk("read_error", read_error, (e_berr || e_mism) ? 1 : 0);
                chk("buffer_read_clear", buffer_read_clear, e_clr ? 1 : 0);
                if (!e_berr) chk("read_data", read_data, m_data[e_ridx]);
            end else begin
                chk("read_grant idle", read_grant, 0);
                chk("read_error idle", read_error, 0);
                chk("buffer_read_clear idle", buffer_read_clear, 0);
            end
            for (int i = 0; i < R; i++)
                chk($sformatf("outstanding%0d", i), outstanding[i*CW +: CW], m_cnt[i]);
            chk("buffer_resetn", buffer_resetn, 1);
        end
    endtask

    task automatic model_update();
        int n;
        bit dec;
        if (reset) begin
            m_wptr = 0;
            m_rptr = 0;
            for (int i = 0; i < R; i++) m_cnt[i] = 0;
            for (int s = 0; s < DEPTH; s++) begin m_valid[s] = 0; m_owner[s] = 0; end
        end else begin
            dec = 1'b0;
            if (e_wwin >= 0) begin
                m_valid[e_free] = 1'b1;
                m_data[e_free]  = write_data[e_wwin*WIDTH +: WIDTH];
                m_owner[e_free] = e_wwin;
                m_wptr          = (e_wwin + 1) % R;
            end
            if (e_rwin >= 0) begin
                m_rptr = (e_rwin + 1) % R;
                if (e_clr && !e_berr) begin
                    m_valid[e_ridx] = 1'b0;
                    dec = 1'b1;
                end
            end
            for (int i = 0; i < R; i++) begin
                n = m_cnt[i] + ((i == e_wwin) ? 1 : 0) - ((dec && i == e_rwin) ? 1 : 0);
                m_cnt[i] = (n < 0) ? 0 : (n > QUOTA) ? QUOTA : n;
            end
        end
    endtask

    task automatic cyc_begin();
        #1;
        model_check();
    endtask

    task automatic cyc_end();
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        write_request = '0;
        write_data    = '0;
        read_request  = '0;
        read_clear    = '0;
        read_index    = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) begin cyc_begin(); cyc_end(); end
        reset = 1'b0;
    endtask

    function automatic logic [R*IW-1:0] pidx(input int a, input int b, input int c, input int d);
        return {IW'(d), IW'(c), IW'(b), IW'(a)};
    endfunction

    typedef struct {
        logic [R-1:0]       wreq;
        logic [R*WIDTH-1:0] wdata;
        logic [R-1:0]       rreq;
        logic [R-1:0]       rclr;
        logic [R*IW-1:0]    ridx;
        logic [R-1:0]       exp_wg;
        logic [IW-1:0]      exp_wi;
        logic [R-1:0]       exp_rg;
        logic               exp_rerr;
        logic [WIDTH-1:0]   exp_rdata;
        bit                 chk_rdata;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{4'hF, 32'hA3A2A1A0, 4'h0, 4'h0, pidx(0,0,0,0), 4'h1, 3'd0, 4'h0, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{4'hF, 32'hA3A2A1A0, 4'h0, 4'h0, pidx(0,0,0,0), 4'h2, 3'd1, 4'h0, 1'b0, 8'h00, 1'b0};
        tbl[2] = '{4'hF, 32'hA3A2A1A0, 4'h0, 4'h0, pidx(0,0,0,0), 4'h4, 3'd2, 4'h0, 1'b0, 8'h00, 1'b0};
        tbl[3] = '{4'hF, 32'hA3A2A1A0, 4'h0, 4'h0, pidx(0,0,0,0), 4'h8, 3'd3, 4'h0, 1'b0, 8'h00, 1'b0};
        tbl[4] = '{4'h0, 32'h0,        4'h1, 4'h0, pidx(0,0,0,0), 4'h0, 3'd0, 4'h1, 1'b0, 8'hA0, 1'b1};
        tbl[5] = '{4'h0, 32'h0,        4'h4, 4'h4, pidx(0,0,2,0), 4'h0, 3'd0, 4'h4, 1'b0, 8'hA2, 1'b1};
        tbl[6] = '{4'h0, 32'h0,        4'h9, 4'h0, pidx(0,0,0,3), 4'h0, 3'd0, 4'h8, 1'b0, 8'hA3, 1'b1};
        tbl[7] = '{4'h0, 32'h0,        4'h9, 4'h0, pidx(0,0,0,3), 4'h0, 3'd0, 4'h1, 1'b0, 8'hA0, 1'b1};
        tbl[8] = '{4'h0, 32'h0,        4'h2, 4'h0, pidx(0,5,0,0), 4'h0, 3'd0, 4'h2, 1'b1, 8'h00, 1'b0};
        tbl[9] = '{4'h2, 32'h0000B100, 4'h0, 4'h0, pidx(0,0,0,0), 4'h2, 3'd2, 4'h0, 1'b0, 8'h00, 1'b0};

        idle_inputs();
        reset = 1'b1;
        @(negedge clock);
        do_reset();
        chk("after reset outstanding", outstanding, 0);

        for (int v = 0; v < 10; v++) begin
            write_request = tbl[v].wreq;
            write_data    = tbl[v].wdata;
            read_request  = tbl[v].rreq;
            read_clear    = tbl[v].rclr;
            read_index    = tbl[v].ridx;
            cyc_begin();
            chk($sformatf("vec%0d write_grant", v), write_grant, tbl[v].exp_wg);
            if (tbl[v].exp_wg != 0) chk($sformatf("vec%0d write_index", v), write_index, tbl[v].exp_wi);
            chk($sformatf("vec%0d read_grant", v), read_grant, tbl[v].exp_rg);
            if (tbl[v].exp_rg != 0) chk($sformatf("vec%0d read_error", v), read_error, tbl[v].exp_rerr);
            if (tbl[v].chk_rdata) chk($sformatf("vec%0d read_data", v), read_data, tbl[v].exp_rdata);
            cyc_end();
        end

        // Quota: client 2 alone.
        do_reset();
        write_request = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            write_data = {8'h00, 8'hC0 + 8'(k), 16'h0000};
            cyc_begin();
            chk($sformatf("quota grant%0d", k), write_grant, (k < 4) ? 4 : 0);
            if (k < 4) chk($sformatf("quota index%0d", k), write_index, k);
            cyc_end();
        end
        read_request = 4'b0100;
        read_clear   = 4'b0100;
        read_index   = pidx(0,0,1,0);
        cyc_begin();
        chk("quota clear fwd", buffer_read_clear, 1);
        chk("quota blocked", write_grant, 0);
        cyc_end();
        idle_inputs();
        write_request = 4'b0100;
        cyc_begin();
        chk("quota regrant", write_grant, 4);
        chk("quota reindex", write_index, 1);
        cyc_end();

        // Full buffer: clients 0 and 1 fill all slots.
        do_reset();
        write_request = 4'b0011;
        write_data    = {16'h0000, 8'h11, 8'h10};
        for (int k = 0; k < 8; k++) begin
            cyc_begin();
            chk($sformatf("fill grant%0d", k), write_grant, (k % 2 == 0) ? 1 : 2);
            chk($sformatf("fill index%0d", k), write_index, k);
            cyc_end();
        end
        cyc_begin();
        chk("full flag", buffer_full, 1);
        chk("full no grant", write_grant, 0);
        cyc_end();
        read_request = 4'b0001;
        read_clear   = 4'b0001;
        read_index   = pidx(0,0,0,0);
        cyc_begin();
        chk("full clear cycle grant", write_grant, 0);
        chk("full clear fwd", buffer_read_clear, 1);
        cyc_end();
        read_request = '0;
        read_clear   = '0;
        cyc_begin();
        chk("after clear grant", write_grant, 1);
        chk("after clear index", write_index, 0);
        cyc_end();

        // Foreign clear.
        do_reset();
        write_request = 4'b0001;
        write_data    = 32'h000000A0;
        cyc_begin();
        chk("own write grant", write_grant, 1);
        cyc_end();
        idle_inputs();
        read_request = 4'b0010;
        read_clear   = 4'b0010;
        read_index   = pidx(0,0,0,0);
        cyc_begin();
        chk("foreign read_data", read_data, 8'hA0);
        chk("foreign read_error", read_error, OWN ? 1 : 0);
        chk("foreign clear", buffer_read_clear, OWN ? 0 : 1);
        cyc_end();
        read_request = 4'b0001;
        read_clear   = 4'b0000;
        cyc_begin();
        chk("owner reread grant", read_grant, 1);
        chk("owner reread error", read_error, OWN ? 0 : 1);
        cyc_end();

        // Reset in the middle of traffic.
        do_reset();
        write_request = 4'hF;
        write_data    = 32'hD3D2D1D0;
        repeat (5) begin cyc_begin(); cyc_end(); end
        reset = 1'b1;
        cyc_begin();
        chk("midreset grant", write_grant, 0);
        cyc_end();
        reset = 1'b0;
        write_request = 4'b0110;
        cyc_begin();
        chk("midreset outstanding", outstanding, 0);
        chk("midreset full", buffer_full, 0);
        chk("midreset first grant", write_grant, 2);
        chk("midreset first index", write_index, 0);
        cyc_end();

        // Random traffic, biased so reads often target the client's own slots.
        for (int n = 0; n < 3000; n++) begin
            reset         = ($urandom_range(99, 0) == 0);
            write_request = R'($urandom);
            write_data    = $urandom;
            read_request  = R'($urandom);
            read_clear    = R'($urandom);
            for (int i = 0; i < R; i++) begin
                int pick;
                int off;
                pick = $urandom_range(DEPTH - 1, 0);
                if ($urandom_range(1, 0) == 1) begin
                    off = $urandom_range(DEPTH - 1, 0);
                    for (int s = 0; s < DEPTH; s++) begin
                        int q;
                        q = (off + s) % DEPTH;
                        if (m_valid[q] && m_owner[q] == i) pick = q;
                    end
                end
                read_index[i*IW +: IW] = IW'(pick);
            end
            cyc_begin();
            cyc_end();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
